// File: rtl/ycbcr_to_rgb_stream_pkg.sv
// Shared types and Q8 conversion constants for the YCbCr block-to-RGB pixel stream.
package ycbcr_to_rgb_stream_pkg;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } ch_t;

    localparam logic [1:0] CH_NONE = 2'd3;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_STREAM  = 1'b1
    } state_t;

    typedef logic signed [7:0] sample_t;
    typedef sample_t [7:0][7:0] block_t;

    localparam logic signed [31:0] K_R_CR  = 32'sd359;
    localparam logic signed [31:0] K_G_CB  = 32'sd88;
    localparam logic signed [31:0] K_G_CR  = 32'sd183;
    localparam logic signed [31:0] K_B_CB  = 32'sd454;
    localparam int                 Q_SHIFT = 8;

endpackage

// File: rtl/ycbcr_to_rgb_stream_pixel.sv
// Combinational YCbCr -> RGB conversion of one pixel in Q8 fixed point, clamped to 0..255.
module ycc_pixel_to_rgb
    import ycbcr_to_rgb_stream_pkg::*;
(
    input  logic signed [7:0] y_i,
    input  logic signed [7:0] cb_i,
    input  logic signed [7:0] cr_i,
    output logic        [7:0] r_o,
    output logic        [7:0] g_o,
    output logic        [7:0] b_o
);

    // Round-half-up then floor shift back from Q8.
    function automatic logic signed [31:0] q8_round(input logic signed [31:0] p);
        return (p + (32'sd1 <<< (Q_SHIFT - 1))) >>> Q_SHIFT;
    endfunction

    function automatic logic [7:0] sat_u8(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic signed [31:0] y_ext;
    logic signed [31:0] cb_ext;
    logic signed [31:0] cr_ext;
    logic signed [31:0] r_s;
    logic signed [31:0] g_s;
    logic signed [31:0] b_s;

    assign y_ext  = 32'(y_i) + 32'sd128;
    assign cb_ext = 32'(cb_i);
    assign cr_ext = 32'(cr_i);

    assign r_s = y_ext + q8_round(K_R_CR * cr_ext);
    assign g_s = y_ext + q8_round(-(K_G_CB * cb_ext) - (K_G_CR * cr_ext));
    assign b_s = y_ext + q8_round(K_B_CB * cb_ext);

    assign r_o = sat_u8(r_s);
    assign g_o = sat_u8(g_s);
    assign b_o = sat_u8(b_s);

endmodule

// File: rtl/ycbcr_to_rgb_stream.sv
// Buffers one Y/Cb/Cr 8x8 block set, then streams 64 RGB pixels in raster order
// through a single-entry valid/ready output register.
module ycbcr_to_rgb_stream
    import ycbcr_to_rgb_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ch_in,
    input  logic        valid_in,
    output logic        ready_in,
    input  block_t      block_in,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [2:0]  row_out,
    output logic [2:0]  col_out,
    output logic        last_out,
    output logic        valid_out,
    input  logic        ready_out
);

    state_t     state_q, state_d;
    logic [2:0] mask_q, mask_d;
    logic [5:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       last_q, last_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0] row_q, row_d, col_q, col_d;

    block_t     y_buf_q, cb_buf_q, cr_buf_q;

    sample_t    y_sel, cb_sel, cr_sel;
    logic [7:0] pix_r, pix_g, pix_b;

    assign y_sel  = y_buf_q[idx_q[5:3]][idx_q[2:0]];
    assign cb_sel = cb_buf_q[idx_q[5:3]][idx_q[2:0]];
    assign cr_sel = cr_buf_q[idx_q[5:3]][idx_q[2:0]];

    ycc_pixel_to_rgb u_conv (
        .y_i  (y_sel),
        .cb_i (cb_sel),
        .cr_i (cr_sel),
        .r_o  (pix_r),
        .g_o  (pix_g),
        .b_o  (pix_b)
    );

    assign ready_in = (state_q == ST_COLLECT);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        last_d  = last_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        row_d   = row_q;
        col_d   = col_q;

        case (state_q)
            ST_COLLECT: begin
                if (valid_in && (ch_in != CH_NONE)) begin
                    mask_d = mask_q | (3'b001 << ch_in);
                    if (mask_d == 3'b111) begin
                        state_d = ST_STREAM;
                        idx_d   = 6'd0;
                    end
                end
            end
            ST_STREAM: begin
                if (!vld_q || ready_out) begin
                    // Pixel 63 is leaving: the block set is finished.
                    if (vld_q && last_q) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        mask_d  = 3'b000;
                        state_d = ST_COLLECT;
                    end else begin
                        vld_d  = 1'b1;
                        r_d    = pix_r;
                        g_d    = pix_g;
                        b_d    = pix_b;
                        row_d  = idx_q[5:3];
                        col_d  = idx_q[2:0];
                        last_d = (idx_q == 6'd63);
                        idx_d  = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            mask_q  <= 3'b000;
            idx_q   <= 6'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Sample buffers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if ((state_q == ST_COLLECT) && valid_in) begin
            case (ch_in)
                CH_Y:    y_buf_q  <= block_in;
                CH_CB:   cb_buf_q <= block_in;
                CH_CR:   cr_buf_q <= block_in;
                default: ;
            endcase
        end
    end

    assign r_out     = r_q;
    assign g_out     = g_q;
    assign b_out     = b_q;
    assign row_out   = row_q;
    assign col_out   = col_q;
    assign last_out  = last_q;
    assign valid_out = vld_q;

endmodule
